// File: rtl/arb_client_mux.sv
// Requester-side companion to the round-robin arbiter: per-client FIFOs drive arb_req and
// the granted head is forwarded to one valid/ready output. ARB_CLIENT_MUX_STATS_EN adds hit counters.

module arb_client_mux_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;

  // Extra pointer bit separates full from empty when the indices match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

module arb_client_mux #(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*W-1:0]       in_data,
  output logic [N-1:0]         arb_req,
  input  logic [N-1:0]         arb_grant,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_src,
  output logic                 grant_err
`ifdef ARB_CLIENT_MUX_STATS_EN
  ,
  output logic [N*16-1:0]      stat_cnt
`endif
);
  localparam int SW = $clog2(N);

  typedef enum logic {IDLE, BUSY} state_e;
  state_e state_q, state_d;

  logic [N-1:0]        full, empty, push, pop;
  logic [N-1:0][W-1:0] head;
  logic                onehot, hit;
  logic [SW-1:0]       gidx;
  logic [W-1:0]        gdata;
  logic [W-1:0]        out_data_q, out_data_d;
  logic [SW-1:0]       out_src_q, out_src_d;
  logic                grant_err_q, grant_err_d;

  for (genvar i = 0; i < N; i++) begin : g_fifo
    assign push[i] = in_valid[i] && !full[i];
    arb_client_mux_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (in_data[i*W +: W]),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end
  assign in_ready = ~full;

  always_comb begin
    gidx  = '0;
    gdata = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_grant[i]) begin
        gidx  = SW'(i);
        gdata = head[i];
      end
    end
  end

  assign onehot = (arb_grant != '0) && ((arb_grant & (arb_grant - 1'b1)) == '0);
  assign hit    = (state_q == IDLE) && onehot && |(arb_grant & ~empty);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit) state_d = BUSY;
      BUSY:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Requests are withheld on the hit cycle and while BUSY so the arbiter grant is 0 on re-entry.
  always_comb begin
    arb_req     = (state_q == IDLE && !hit) ? ~empty : '0;
    pop         = hit ? arb_grant : '0;
    out_valid   = (state_q == BUSY);
    out_data_d  = hit ? gdata : out_data_q;
    out_src_d   = hit ? gidx  : out_src_q;
    grant_err_d = grant_err_q | ((state_q == IDLE) && (arb_grant != '0) && !hit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      grant_err_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      grant_err_q <= grant_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign grant_err = grant_err_q;

`ifdef ARB_CLIENT_MUX_STATS_EN
  logic [N-1:0][15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < N; i++)
      if (pop[i] && stat_q[i] != 16'hFFFF) stat_d[i] = stat_q[i] + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stat_cnt = stat_q;
`endif
endmodule
